// File: rtl/rths_pkg.sv
// Shared types and constant helpers for the mesh_sorter shear-sort block.
package rths_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SORT,
    DONE
  } state_t;

  typedef enum logic {
    ROW,
    COL
  } phase_t;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    for (int unsigned p = 1; p < v; p = p << 1) r++;
    return r;
  endfunction

  // Number of shear-sort phases for an n x n matrix: log2(n)+1 row phases
  // interleaved with log2(n) column phases.
  function automatic int unsigned PHASES(input int unsigned n);
    return 2 * clog2(n) + 1;
  endfunction

endpackage

// File: rtl/line_sorter.sv
// Combinational bitonic sorting network for one line of NUM unsigned keys.
// dir_i = 0 sorts ascending by index, dir_i = 1 sorts descending.
module line_sorter
  import rths_pkg::*;
#(
  parameter int unsigned NUM = 4,
  parameter int unsigned W   = 64
) (
  input  logic             dir_i,
  input  logic [NUM*W-1:0] line_i,
  output logic [NUM*W-1:0] line_o
);

  logic [W-1:0] v [NUM];
  logic [W-1:0] t;

  // Full bitonic network unrolled as compare-exchange stages.
  always_comb begin
    t      = '0;
    line_o = '0;
    for (int unsigned i = 0; i < NUM; i++) v[i] = line_i[W*i +: W];
    for (int unsigned k = 2; k <= NUM; k = k << 1) begin
      for (int unsigned j = k >> 1; j > 0; j = j >> 1) begin
        for (int unsigned i = 0; i < NUM; i++) begin
          if ((i ^ j) > i) begin
            // Sub-sequence direction flips with bit k; the final merge (k = NUM)
            // follows dir_i for the whole line.
            if ((((i & k) == 0) != dir_i) ? (v[i] > v[i ^ j]) : (v[i] < v[i ^ j])) begin
              t         = v[i];
              v[i]      = v[i ^ j];
              v[i ^ j]  = t;
            end
          end
        end
      end
    end
    for (int unsigned i = 0; i < NUM; i++) line_o[W*i +: W] = v[i];
  end

endmodule

// File: rtl/mesh_sorter.sv
// Shear-sort of a NUM x NUM matrix of unsigned W-bit keys using NUM shared
// line sorters, one phase (all rows or all columns) per clock.
// Optional macro RTHS_DESC_EN: adds the desc port for descending order;
// without it the order is fixed ascending.
module mesh_sorter
  import rths_pkg::*;
#(
  parameter int unsigned NUM = 4,
  parameter int unsigned W   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
`ifdef RTHS_DESC_EN
  input  logic                 desc,
`endif
  input  logic [NUM*NUM*W-1:0] keyIn,
  output logic [NUM*NUM*W-1:0] keyOut,
  output logic                 busy,
  output logic                 ready
);

  localparam int unsigned N2 = NUM * NUM;
  localparam int unsigned P  = PHASES(NUM);
  localparam int unsigned PW = clog2(P + 1);

  state_t               state_q, state_d;
  logic [PW-1:0]        phase_q, phase_d;
  logic [W-1:0]         mat_q [N2];
  logic [W-1:0]         mat_d [N2];
  logic [N2*W-1:0]      keyout_q, keyout_d;
  logic                 ready_q, ready_d;
  logic                 order;
  phase_t               ptype;

  logic [NUM*W-1:0]     ln_in  [NUM];
  logic [NUM*W-1:0]     ln_out [NUM];
  logic                 ln_dir [NUM];

`ifdef RTHS_DESC_EN
  logic                 desc_q, desc_d;
  assign order = desc_q;
`else
  assign order = 1'b0;
`endif

  assign ptype  = phase_q[0] ? COL : ROW;
  assign busy   = (state_q != IDLE);
  assign ready  = ready_q;
  assign keyOut = keyout_q;

  // Route rows (snake direction) or columns onto the shared line sorters.
  always_comb begin
    for (int unsigned n = 0; n < NUM; n++) begin
      ln_in[n]  = '0;
      ln_dir[n] = order ^ ((ptype == ROW) && ((n & 1) != 0));
      for (int unsigned m = 0; m < NUM; m++) begin
        ln_in[n][W*m +: W] = (ptype == ROW) ? mat_q[n*NUM + m] : mat_q[m*NUM + n];
      end
    end
  end

  for (genvar g = 0; g < NUM; g++) begin : g_line
    line_sorter #(.NUM(NUM), .W(W)) u_line (
      .dir_i  (ln_dir[g]),
      .line_i (ln_in[g]),
      .line_o (ln_out[g])
    );
  end

  // Next-state: FSM, phase counter, matrix update and output capture.
  always_comb begin
    state_d  = state_q;
    phase_d  = phase_q;
    mat_d    = mat_q;
    keyout_d = keyout_q;
    ready_d  = 1'b0;
`ifdef RTHS_DESC_EN
    desc_d   = desc_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SORT;
          phase_d = '0;
          for (int unsigned i = 0; i < N2; i++) mat_d[i] = keyIn[W*i +: W];
`ifdef RTHS_DESC_EN
          desc_d  = desc;
`endif
        end
      end
      SORT: begin
        for (int unsigned r = 0; r < NUM; r++) begin
          for (int unsigned c = 0; c < NUM; c++) begin
            mat_d[r*NUM + c] = (ptype == ROW) ? ln_out[r][W*c +: W] : ln_out[c][W*r +: W];
          end
        end
        phase_d = phase_q + 1'b1;
        if (phase_q == PW'(P - 1)) state_d = DONE;
      end
      DONE: begin
        // Undo the snake: odd rows were sorted in the opposite direction.
        for (int unsigned r = 0; r < NUM; r++) begin
          for (int unsigned c = 0; c < NUM; c++) begin
            keyout_d[W*(r*NUM + c) +: W] =
              mat_q[r*NUM + (((r & 1) != 0) ? (NUM - 1 - c) : c)];
          end
        end
        ready_d = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      phase_q  <= '0;
      mat_q    <= '{default: '0};
      keyout_q <= '0;
      ready_q  <= 1'b0;
`ifdef RTHS_DESC_EN
      desc_q   <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      phase_q  <= phase_d;
      mat_q    <= mat_d;
      keyout_q <= keyout_d;
      ready_q  <= ready_d;
`ifdef RTHS_DESC_EN
      desc_q   <= desc_d;
`endif
    end
  end

endmodule

// File: tb/tb_mesh_sorter.sv
// Self-checking bench for mesh_sorter: NUM=4/W=8 and NUM=8/W=16 instances.
module tb_mesh_sorter;

  localparam int PA = 5;
  localparam int PB = 7;

  logic          clk = 1'b0;
  logic          rst;
  logic          start_a, start_b;
  logic [127:0]  key_a, out_a;
  logic [1023:0] key_b, out_b;
  logic          busy_a, ready_a, busy_b, ready_b;
`ifdef RTHS_DESC_EN
  logic          desc_a, desc_b;
`endif

  int checks = 0;
  int errors = 0;
  int ready_cnt_a = 0;
  int ready_cnt_b = 0;
  logic [1023:0] q_a[$];
  logic [1023:0] q_b[$];
  logic [127:0]  prev_a;
  logic [1023:0] prev_b;

  typedef struct {
    logic [127:0] keys;
    logic         dsc;
    logic [127:0] exp;
  } vec_t;
  vec_t tbl[$];

  always #5 clk = ~clk;

  mesh_sorter #(.NUM(4), .W(8)) u_a (
    .clk(clk), .rst(rst), .start(start_a),
`ifdef RTHS_DESC_EN
    .desc(desc_a),
`endif
    .keyIn(key_a), .keyOut(out_a), .busy(busy_a), .ready(ready_a)
  );

  mesh_sorter #(.NUM(8), .W(16)) u_b (
    .clk(clk), .rst(rst), .start(start_b),
`ifdef RTHS_DESC_EN
    .desc(desc_b),
`endif
    .keyIn(key_b), .keyOut(out_b), .busy(busy_b), .ready(ready_b)
  );

  task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain insertion sort on n keys of w bits.
  function automatic logic [1023:0] ref_sort(input logic [1023:0] keys, input int n,
                                             input int w, input logic dsc);
    int unsigned a[64];
    int unsigned t;
    int unsigned mask;
    logic [1023:0] r;
    mask = (32'd1 << w) - 1;
    for (int i = 0; i < n; i++) a[i] = 32'(keys >> (i * w)) & mask;
    for (int i = 1; i < n; i++) begin
      t = a[i];
      for (int j = i - 1; j >= 0; j--) begin
        if (dsc ? (a[j] < t) : (a[j] > t)) begin
          a[j + 1] = a[j];
          a[j] = t;
        end else break;
      end
    end
    r = '0;
    for (int i = 0; i < n; i++) r = r | (1024'(a[i]) << (i * w));
    return r;
  endfunction

  // Scoreboard: each ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (ready_a) begin
      ready_cnt_a++;
      if (q_a.size() == 0) check("unexpected_ready_a", 1024'(1), 1024'(0));
      else check("keyOut_a", 1024'(out_a), q_a.pop_front());
    end
    if (ready_b) begin
      ready_cnt_b++;
      if (q_b.size() == 0) check("unexpected_ready_b", 1024'(1), 1024'(0));
      else check("keyOut_b", out_b, q_b.pop_front());
    end
  end

  task automatic run_a(input logic [127:0] keys, input logic dsc, input logic [127:0] exp);
    int lat, bcnt;
    @(negedge clk);
    start_a = 1'b1;
    key_a   = keys;
`ifdef RTHS_DESC_EN
    desc_a  = dsc;
`endif
    q_a.push_back(1024'(exp));
    @(negedge clk);
    start_a = 1'b0;
    key_a   = '1;
    lat = 0;
    bcnt = 0;
    for (int n = 1; n <= 20 && lat == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (busy_a) bcnt++;
      if (n == 3) check("hold_a", 1024'(out_a), 1024'(prev_a));
      if (ready_a) lat = n;
    end
    check("ready_latency_a", 1024'(lat), 1024'(PA + 2));
    check("busy_cycles_a", 1024'(bcnt), 1024'(PA + 1));
    prev_a = exp;
  endtask

  task automatic run_b(input logic [1023:0] keys, input logic dsc);
    int lat, bcnt;
    logic [1023:0] exp;
    exp = ref_sort(keys, 64, 16, dsc);
    @(negedge clk);
    start_b = 1'b1;
    key_b   = keys;
`ifdef RTHS_DESC_EN
    desc_b  = dsc;
`endif
    q_b.push_back(exp);
    @(negedge clk);
    start_b = 1'b0;
    lat = 0;
    bcnt = 0;
    for (int n = 1; n <= 24 && lat == 0; n++) begin
      if (n > 1) @(negedge clk);
      if (busy_b) bcnt++;
      if (n == 4) check("hold_b", out_b, prev_b);
      if (ready_b) lat = n;
    end
    check("ready_latency_b", 1024'(lat), 1024'(PB + 2));
    check("busy_cycles_b", 1024'(bcnt), 1024'(PB + 1));
    prev_b = exp;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [127:0]  rev, fwd, expA, kB;
    logic [1023:0] tmp, kb;
    int r0;
    logic d;

    rst = 1'b1; start_a = 1'b0; start_b = 1'b0; key_a = '0; key_b = '0;
`ifdef RTHS_DESC_EN
    desc_a = 1'b0; desc_b = 1'b0;
`endif
    prev_a = '0; prev_b = '0;

    // Vector table
    for (int i = 0; i < 16; i++) begin
      rev[8*i +: 8] = 8'(15 - i);
      fwd[8*i +: 8] = 8'(i);
    end
    v.keys = rev; v.dsc = 1'b0; v.exp = fwd; tbl.push_back(v);
`ifdef RTHS_DESC_EN
    v.keys = rev; v.dsc = 1'b1; v.exp = rev; tbl.push_back(v);
    v.keys = fwd; v.dsc = 1'b1; v.exp = rev; tbl.push_back(v);
`endif
    v.keys = {16{8'hA5}}; v.dsc = 1'b0; v.exp = {16{8'hA5}}; tbl.push_back(v);
    v.keys = fwd; v.dsc = 1'b0; v.exp = fwd; tbl.push_back(v);
    v.keys = {8'h00, 8'hFF, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h00, 8'hFF,
              8'h7F, 8'h80, 8'h10, 8'h0F, 8'hF0, 8'h00, 8'hFF, 8'h55};
    v.dsc = 1'b0;
    tmp = ref_sort(1024'(v.keys), 16, 8, 1'b0); v.exp = tmp[127:0]; tbl.push_back(v);
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 16; i++) v.keys[8*i +: 8] = 8'($urandom_range(0, 7) * 37);
      v.dsc = 1'b0;
      tmp = ref_sort(1024'(v.keys), 16, 8, 1'b0); v.exp = tmp[127:0]; tbl.push_back(v);
    end

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_keyOut_a", 1024'(out_a), '0);
    check("reset_busy_a", 1024'(busy_a), '0);
    check("reset_ready_a", 1024'(ready_a), '0);
    check("reset_keyOut_b", out_b, '0);
    check("reset_busy_b", 1024'(busy_b), '0);
    rst = 1'b0;

    for (int t = 0; t < tbl.size(); t++) run_a(tbl[t].keys, tbl[t].dsc, tbl[t].exp);

    // Back-to-back: start in the ready cycle is accepted
    @(negedge clk);
    start_a = 1'b1; key_a = rev; q_a.push_back(1024'(fwd));
    for (int n = 0; n < 12 && !ready_a; n++) @(negedge clk);
    key_a = {16{8'h3C}}; q_a.push_back(1024'({16{8'h3C}}));
    @(negedge clk);
    start_a = 1'b0;
    r0 = ready_cnt_a;
    for (int n = 0; n < 12 && ready_cnt_a == r0; n++) @(negedge clk);
    check("b2b_second_ready_a", 1024'(ready_cnt_a - r0), 1024'(1));
    prev_a = {16{8'h3C}};

    // Start during busy is ignored
    r0 = ready_cnt_a;
    expA = fwd;
    @(negedge clk);
    start_a = 1'b1; key_a = rev; q_a.push_back(1024'(expA));
    @(negedge clk);
    start_a = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 16; i++) kB[8*i +: 8] = 8'(200 + i);
    start_a = 1'b1; key_a = kB;
    @(negedge clk);
    start_a = 1'b0;
    repeat (20) @(negedge clk);
    check("busy_start_ready_count", 1024'(ready_cnt_a - r0), 1024'(1));
    prev_a = expA;

    // Reset mid-sort
    r0 = ready_cnt_a;
    @(negedge clk);
    start_a = 1'b1; key_a = kB;
    @(negedge clk);
    start_a = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_keyOut_a", 1024'(out_a), '0);
    check("abort_busy_a", 1024'(busy_a), '0);
    check("abort_ready_a", 1024'(ready_a), '0);
    repeat (15) @(negedge clk);
    check("abort_no_ready", 1024'(ready_cnt_a - r0), '0);
    prev_a = '0;
    prev_b = '0;
    run_a(kB, 1'b0, kB);
    run_a(rev, 1'b0, fwd);

    // NUM=8, W=16 random regression
    for (int k = 0; k < 1000; k++) begin
      for (int i = 0; i < 64; i++) begin
        case (k % 4)
          0: kb[16*i +: 16] = 16'($urandom_range(0, 15));
          1: kb[16*i +: 16] = ($urandom_range(0, 1) != 0) ? 16'hFFFF : 16'($urandom_range(0, 65535));
          default: kb[16*i +: 16] = 16'($urandom_range(0, 65535));
        endcase
      end
`ifdef RTHS_DESC_EN
      d = 1'($urandom_range(0, 1));
`else
      d = 1'b0;
`endif
      run_b(kb, d);
    end

    repeat (3) @(negedge clk);
    check("scoreboard_empty_a", 1024'(q_a.size()), '0);
    check("scoreboard_empty_b", 1024'(q_b.size()), '0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
